// File: rtl/mm_mac_scheduler.sv
// mm_mac_scheduler: sequences M1/M2 register-file reads and MAC strobes for one C = M1*M2 job,
// presenting each finished C[i][j] with a valid/ready handshake.
module mm_mac_scheduler #(
   parameter int IDX_W = 4,
   parameter int DIM_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIM_W-1:0] m1_rows,
   input  logic [DIM_W-1:0] m1_cols,
   input  logic [DIM_W-1:0] m2_rows,
   input  logic [DIM_W-1:0] m2_cols,
   input  logic             out_ready,
   output logic             busy,
   output logic             is_legal,
   output logic [IDX_W-1:0] m1_read_idx,
   output logic [IDX_W-1:0] m2_read_idx,
   output logic             acc_clr,
   output logic             acc_en,
   output logic             valid,
   output logic             change_row,
   output logic             done
);
   typedef enum logic [2:0] {IDLE, CHECK, MAC, EMIT, DONE} state_t;
   state_t state_q, state_d;
   logic [DIM_W-1:0] m1r_q, m1r_d, m1c_q, m1c_d, m2r_q, m2r_d, m2c_q, m2c_d;
   logic [DIM_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
   logic [IDX_W-1:0] m1_idx_q, m1_idx_d, m2_idx_q, m2_idx_d;
   logic legal_q, legal_d, busy_q, busy_d, clr_q, clr_d, en_q, en_d;
   logic valid_q, valid_d, row_q, row_d, done_q, done_d;
   always_comb begin
      state_d = state_q;
      m1r_d = m1r_q;
      m1c_d = m1c_q;
      m2r_d = m2r_q;
      m2c_d = m2c_q;
      i_d = i_q;
      j_d = j_q;
      k_d = k_q;
      legal_d = legal_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = CHECK;
            m1r_d = m1_rows;
            m1c_d = m1_cols;
            m2r_d = m2_rows;
            m2c_d = m2_cols;
            legal_d = 1'b0;
         end
         CHECK: begin
            legal_d = (m1c_q == m2r_q);
            state_d = legal_d ? MAC : DONE;
            i_d = '0;
            j_d = '0;
            k_d = '0;
         end
         MAC: if (k_q == m1c_q) state_d = EMIT; else k_d = k_q + 1'b1;
         EMIT: if (out_ready) begin
            if (i_q == m1r_q && j_q == m2c_q) state_d = DONE;
            else begin
               state_d = MAC;
               k_d = '0;
               j_d = (j_q == m2c_q) ? '0 : j_q + 1'b1;
               i_d = (j_q == m2c_q) ? i_q + 1'b1 : i_q;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // outputs are derived from the next state so they line up with the registered state
      busy_d = (state_d != IDLE);
      en_d = (state_d == MAC);
      clr_d = en_d && (k_d == '0);
      valid_d = (state_d == EMIT);
      row_d = valid_d && (j_d == m2c_d);
      done_d = (state_d == DONE);
      m1_idx_d = en_d ? IDX_W'(i_d) * (IDX_W'(m1c_d) + IDX_W'(1)) + IDX_W'(k_d) : valid_d ? m1_idx_q : '0;
      m2_idx_d = en_d ? IDX_W'(k_d) * (IDX_W'(m2c_d) + IDX_W'(1)) + IDX_W'(j_d) : valid_d ? m2_idx_q : '0;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         m1r_q <= '0;
         m1c_q <= '0;
         m2r_q <= '0;
         m2c_q <= '0;
         i_q <= '0;
         j_q <= '0;
         k_q <= '0;
         m1_idx_q <= '0;
         m2_idx_q <= '0;
         legal_q <= 1'b0;
         busy_q <= 1'b0;
         clr_q <= 1'b0;
         en_q <= 1'b0;
         valid_q <= 1'b0;
         row_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         m1r_q <= m1r_d;
         m1c_q <= m1c_d;
         m2r_q <= m2r_d;
         m2c_q <= m2c_d;
         i_q <= i_d;
         j_q <= j_d;
         k_q <= k_d;
         m1_idx_q <= m1_idx_d;
         m2_idx_q <= m2_idx_d;
         legal_q <= legal_d;
         busy_q <= busy_d;
         clr_q <= clr_d;
         en_q <= en_d;
         valid_q <= valid_d;
         row_q <= row_d;
         done_q <= done_d;
      end
   end
   assign busy = busy_q;
   assign is_legal = legal_q;
   assign m1_read_idx = m1_idx_q;
   assign m2_read_idx = m2_idx_q;
   assign acc_clr = clr_q;
   assign acc_en = en_q;
   assign valid = valid_q;
   assign change_row = row_q;
   assign done = done_q;
endmodule

// File: doc/mm_mac_scheduler.md
Name: mm_mac_scheduler

Overview:
- Sequencer for the matrix-multiply datapath.
- On a start pulse it latches the dimensions of M1 (R x K) and M2 (K2 x N) and checks that K == K2.
- It then drives read indices into both matrix register files and clear/enable strobes into the multiply-accumulator, one product term per cycle.
- It presents each finished C[i][j] with a valid/ready handshake toward the output port. It sits between the top-level input loader and the Matrix_Reg/Mul_Adder pair.

Parameters:
IDX_W, 4, width of read indices (16-entry register files, matrices up to 4x4)
DIM_W, 2, width of dimension fields, encoded as size-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request to begin a multiply; sampled only in IDLE
m1_rows  input  DIM_W  M1 row count minus 1 (R-1)
m1_cols  input  DIM_W  M1 column count minus 1 (K-1)
m2_rows  input  DIM_W  M2 row count minus 1 (K2-1)
m2_cols  input  DIM_W  M2 column count minus 1 (N-1)
out_ready  input  1  downstream accepts the current result
busy  output  1  operation in progress
is_legal  output  1  dimension check result
m1_read_idx  output  IDX_W  M1 register-file read index
m2_read_idx  output  IDX_W  M2 register-file read index
acc_clr  output  1  accumulator loads the product instead of adding it
acc_en  output  1  accumulator updates at the end of this cycle
valid  output  1  accumulator holds a finished C[i][j]
change_row  output  1  the current valid element is the last one of its row
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE and every output and counter is 0. Reset mid-operation aborts the job; no done pulse is issued.
- All outputs are registered.
- Packed row-major storage: m1_read_idx = i*K + k; m2_read_idx = k*N + j. Widths: i, j, k are each 2 bits, the products fit in 4 bits, and there is no wrap.
- States: IDLE, CHECK, MAC, EMIT, DONE.
- IDLE: busy=0. On start=1, latch all four dimension fields, clear is_legal, set busy=1, go to CHECK.
- CHECK (1 cycle): set is_legal = (m1_cols == m2_rows). If legal, go to MAC with i=j=k=0. If illegal, go to DONE.
- MAC (K cycles per element):
  - Each cycle: acc_en=1 and the indices correspond to the current (i, j, k).
  - acc_clr=1 only when k==0.
  - k increments each cycle; after k==K-1, go to EMIT.
- EMIT:
  - valid=1, acc_en=0; indices hold their last values.
  - change_row=1 when j==N-1.
  - valid, change_row and the indices are held stable while out_ready=0.
  - On valid && out_ready: if i==R-1 and j==N-1, go to DONE. Otherwise advance j (wrapping to 0 and incrementing i when j==N-1), reset k to 0 and return to MAC.
- DONE (1 cycle): done=1 and busy=1. Next state is IDLE, where busy=0.
- is_legal holds its value until the next accepted start.
- start is ignored whenever the FSM is not in IDLE.
- Cycle count with out_ready held at 1: busy is high for 1 + R*N*(K+1) + 1 cycles. An illegal job keeps busy high for 2 cycles.
- When out_ready is already 1 on entry to EMIT, valid lasts exactly 1 cycle.

Test Plan:
- 2x3 * 3x2, out_ready=1:
  - For C[0][0]: m1 idx 0,1,2 and m2 idx 0,2,4, with acc_clr only on the first of the three cycles.
  - 4 valid pulses; change_row on the 2nd and 4th.
  - is_legal=1; busy high 18 cycles; done on the last of them.
- 2x3 * 2x2 (m1_cols=2, m2_rows=1): is_legal=0, busy high 2 cycles, done pulses, and valid and acc_en never assert.
- 1x1 * 1x1: one MAC cycle with idx 0/0 and acc_clr=acc_en=1, one valid with change_row=1; busy high 4 cycles.
- Backpressure on 2x2 * 2x2: hold out_ready=0 for 3 cycles at the first EMIT. valid stays 1, indices stay frozen, acc_en stays 0. The first MAC for C[0][1] starts the cycle after out_ready rises.
- 4x4 * 4x4: 16 valid pulses, final MAC cycle has m1 idx 15 and m2 idx 15, busy high 82 cycles. A start pulse applied mid-job is ignored.
- Reset during MAC of a 3x3 job: all outputs are 0 immediately. A new 1x1 job started after reset releases completes normally.
